// File: rtl/device_regs_param.sv
// Parametrised device register bank: NUM_REGS x DATA_W registers, write protection,
// error pulse, registered reads. Optional shadow/commit staging under DEVICE_REGS_SHADOW_EN.
module device_regs_param #(
  parameter int                   DATA_W    = 8,
  parameter int                   NUM_REGS  = 4,
  parameter int                   ADDR_W    = 4,
  parameter logic [NUM_REGS-1:0]  WR_MASK   = {NUM_REGS{1'b1}},
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef DEVICE_REGS_SHADOW_EN
  input  logic                       commit,
`endif
  input  logic [ADDR_W-1:0]          address,
  input  logic                       write_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       read_en,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic                       err,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  localparam int              AW1        = ADDR_W + 1;
  localparam logic [ADDR_W:0] NUM_REGS_W = AW1'(NUM_REGS);

  logic [DATA_W-1:0]   active_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_mux;
  logic [NUM_REGS-1:0] wr_hit;
  logic                sel_writable;
  logic                in_range;
  logic                wr_err;
  logic                rd_err;

  // Full-width compare: addresses beyond NUM_REGS never alias onto a real register.
  assign in_range = ({1'b0, address} < NUM_REGS_W);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_writable = 1'b0;
    rd_mux       = '0;
    wr_hit       = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ({1'b0, address} == AW1'(i)) begin
        sel_writable = WR_MASK[i];
        rd_mux       = active_q[i];
        wr_hit[i]    = write_en & WR_MASK[i];
      end
    end
  end

  // sel_writable is 0 for out-of-range addresses, so this also covers range errors.
  assign wr_err = write_en & ~sel_writable;
  assign rd_err = read_en & ~in_range;

`ifdef DEVICE_REGS_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [NUM_REGS];

  // NOTE: the register array is small control state and must come up at RESET_VAL, so it is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RESET_VAL;
        active_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) shadow_q[i] <= data_in;
        // Commit picks up the shadow as it stood before this edge's write.
        if (commit)    active_q[i] <= shadow_q[i];
      end
    end
  end
`else
  // NOTE: the register array is small control state and must come up at RESET_VAL, so it is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) active_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) active_q[i] <= data_in;
      end
    end
  end
`endif

  // NOTE: non-blocking assignments here let a same-edge read see the pre-write register value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (read_en) read_data <= rd_mux;
      read_valid <= read_en;
      err        <= wr_err | rd_err;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = active_q[g];
  end

endmodule

// File: tb/tb_device_regs_param.sv
// Self-checking bench for device_regs_param: a fully writable instance and a WR_MASK=4'b1011
// instance share stimulus and are compared against an array-based reference model.
module tb_device_regs_param;

  localparam logic [3:0] MASK_B = 4'b1011;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       write_en = 1'b0;
  logic       read_en  = 1'b0;
  logic       commit_s = 1'b0;
  logic [3:0] address  = '0;
  logic [7:0] data_in  = '0;

  logic [7:0]  rd_a, rd_b;
  logic        rv_a, rv_b, err_a, err_b;
  logic [31:0] flat_a, flat_b;

  int checks = 0;
  int errors = 0;

  // Reference model: active (m*) and shadow (s*) register images plus expected outputs.
  logic [7:0] ma [4];
  logic [7:0] mb [4];
  logic [7:0] sa [4];
  logic [7:0] sb [4];
  logic [7:0] exp_rd_a, exp_rd_b;
  logic       exp_rv, exp_err_a, exp_err_b;

  always #5 clk = ~clk;

  device_regs_param dut_a (
    .clk(clk), .reset(reset),
`ifdef DEVICE_REGS_SHADOW_EN
    .commit(commit_s),
`endif
    .address(address), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .read_data(rd_a), .read_valid(rv_a), .err(err_a), .regs_flat(flat_a)
  );

  device_regs_param #(.WR_MASK(MASK_B)) dut_b (
    .clk(clk), .reset(reset),
`ifdef DEVICE_REGS_SHADOW_EN
    .commit(commit_s),
`endif
    .address(address), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .read_data(rd_b), .read_valid(rv_b), .err(err_b), .regs_flat(flat_b)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ma[i] = '0; mb[i] = '0; sa[i] = '0; sb[i] = '0;
    end
    exp_rd_a = '0; exp_rd_b = '0; exp_rv = 1'b0; exp_err_a = 1'b0; exp_err_b = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic re, input logic [3:0] a,
                            input logic [7:0] d, input logic cm);
    bit in_rng;
    bit ok_b;
    int idx;
    in_rng = (a < 4);
    idx    = in_rng ? int'(a) : 0;
    ok_b   = in_rng && MASK_B[idx];
    exp_rv = re;
    if (re) begin
      exp_rd_a = in_rng ? ma[idx] : 8'h00;
      exp_rd_b = in_rng ? mb[idx] : 8'h00;
    end
    exp_err_a = (we && !in_rng) || (re && !in_rng);
    exp_err_b = (we && !ok_b)   || (re && !in_rng);
`ifdef DEVICE_REGS_SHADOW_EN
    if (cm) for (int i = 0; i < 4; i++) begin ma[i] = sa[i]; mb[i] = sb[i]; end
    if (we && in_rng) sa[idx] = d;
    if (we && ok_b)   sb[idx] = d;
`else
    if (cm) idx = idx;
    if (we && in_rng) ma[idx] = d;
    if (we && ok_b)   mb[idx] = d;
`endif
  endtask

  // Drive one access for one clock, then leave outputs settled (#1 after the edge).
  task automatic apply(input logic we, input logic re, input logic [3:0] a,
                       input logic [7:0] d, input logic cm);
    write_en = we; read_en = re; address = a; data_in = d; commit_s = cm;
    @(posedge clk);
    #1;
    model_step(we, re, a, d, cm);
    write_en = 1'b0; read_en = 1'b0; commit_s = 1'b0;
  endtask

  task automatic maybe_commit();
`ifdef DEVICE_REGS_SHADOW_EN
    apply(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_a, rv_a, err_a, flat_a} !== '0) begin
      errors++; $display("FAIL reset_a: got rd=%h rv=%b err=%b flat=%h, expected all zero", rd_a, rv_a, err_a, flat_a);
    end
    checks++;
    if ({rd_b, rv_b, err_b, flat_b} !== '0) begin
      errors++; $display("FAIL reset_b: got rd=%h rv=%b err=%b flat=%h, expected all zero", rd_b, rv_b, err_b, flat_b);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_read_after_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 4'(i), 8'h00, 1'b0);
      checks++;
      if (rd_a !== 8'h00 || rv_a !== 1'b1 || err_a !== 1'b0) begin
        errors++; $display("FAIL read_zero[%0d]: got rd=%h rv=%b err=%b, expected rd=00 rv=1 err=0", i, rd_a, rv_a, err_a);
      end
    end
  endtask

  task automatic test_write_read();
    apply(1'b1, 1'b0, 4'd2, 8'h5A, 1'b0);
    maybe_commit();
    apply(1'b0, 1'b1, 4'd2, 8'h00, 1'b0);
    checks++;
    if (rd_a !== 8'h5A || rv_a !== 1'b1) begin
      errors++; $display("FAIL write_read: got rd=%h rv=%b, expected rd=5a rv=1", rd_a, rv_a);
    end
    checks++;
    if (flat_a[23:16] !== 8'h5A) begin
      errors++; $display("FAIL flat_reg2: got %h, expected 5a", flat_a[23:16]);
    end
    apply(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    checks++;
    if (rv_a !== 1'b0 || rd_a !== 8'h5A) begin
      errors++; $display("FAIL read_hold: got rd=%h rv=%b, expected rd=5a rv=0", rd_a, rv_a);
    end
  endtask

  task automatic test_same_cycle_rw();
    apply(1'b1, 1'b0, 4'd1, 8'h11, 1'b0);
    maybe_commit();
    apply(1'b1, 1'b1, 4'd1, 8'h33, 1'b0);
    checks++;
    if (rd_a !== 8'h11) begin
      errors++; $display("FAIL same_cycle_rw: got %h, expected 11", rd_a);
    end
    maybe_commit();
    apply(1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
    checks++;
    if (rd_a !== 8'h33) begin
      errors++; $display("FAIL read_after_rw: got %h, expected 33", rd_a);
    end
  endtask

  task automatic test_protect();
    apply(1'b1, 1'b0, 4'd2, 8'hFF, 1'b0);
    maybe_commit();
    checks++;
    if (flat_b[23:16] !== 8'h00) begin
      errors++; $display("FAIL ro_unchanged: got %h, expected 00", flat_b[23:16]);
    end
    apply(1'b1, 1'b0, 4'd2, 8'hFF, 1'b0);
    checks++;
    if (err_b !== 1'b1 || err_a !== 1'b0) begin
      errors++; $display("FAIL ro_err: got err_b=%b err_a=%b, expected err_b=1 err_a=0", err_b, err_a);
    end
    apply(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    checks++;
    if (err_b !== 1'b0) begin
      errors++; $display("FAIL err_pulse_width: got %b, expected 0", err_b);
    end
    apply(1'b1, 1'b0, 4'd7, 8'hAA, 1'b0);
    checks++;
    if (err_a !== 1'b1 || err_b !== 1'b1 || flat_a !== {ma[3], ma[2], ma[1], ma[0]}) begin
      errors++; $display("FAIL oor_write: got err_a=%b err_b=%b flat=%h, expected 1 1 %h", err_a, err_b, flat_a, {ma[3], ma[2], ma[1], ma[0]});
    end
    apply(1'b0, 1'b1, 4'd9, 8'h00, 1'b0);
    checks++;
    if (rd_b !== 8'h00 || rv_b !== 1'b1 || err_b !== 1'b1) begin
      errors++; $display("FAIL oor_read: got rd=%h rv=%b err=%b, expected rd=00 rv=1 err=1", rd_b, rv_b, err_b);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 4'(i), 8'(8'hA0 + i), 1'b0);
    maybe_commit();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 4'(i), 8'h00, 1'b0);
      checks++;
      if (rv_a !== 1'b1 || rd_a !== 8'(8'hA0 + i)) begin
        errors++; $display("FAIL b2b[%0d]: got rd=%h rv=%b, expected rd=%h rv=1", i, rd_a, rv_a, 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_random();
    logic we, re, cm;
    logic [3:0] a;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      cm = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      apply(we, re, a, 8'($urandom), cm);
      checks++;
      if (rv_a !== exp_rv || rd_a !== exp_rd_a || err_a !== exp_err_a || flat_a !== {ma[3], ma[2], ma[1], ma[0]}) begin
        errors++; $display("FAIL rand_a[%0d]: got rv=%b rd=%h err=%b flat=%h, expected rv=%b rd=%h err=%b flat=%h",
                           n, rv_a, rd_a, err_a, flat_a, exp_rv, exp_rd_a, exp_err_a, {ma[3], ma[2], ma[1], ma[0]});
      end
      checks++;
      if (rv_b !== exp_rv || rd_b !== exp_rd_b || err_b !== exp_err_b || flat_b !== {mb[3], mb[2], mb[1], mb[0]}) begin
        errors++; $display("FAIL rand_b[%0d]: got rv=%b rd=%h err=%b flat=%h, expected rv=%b rd=%h err=%b flat=%h",
                           n, rv_b, rd_b, err_b, flat_b, exp_rv, exp_rd_b, exp_err_b, {mb[3], mb[2], mb[1], mb[0]});
      end
    end
  endtask

  task automatic test_reset_mid_read();
    apply(1'b1, 1'b0, 4'd1, 8'h77, 1'b0);
    maybe_commit();
    read_en = 1'b1; address = 4'd1;
    @(posedge clk);
    #3;
    reset   = 1'b1;
    read_en = 1'b0;
    #1;
    checks++;
    if ({rd_a, rv_a, err_a, flat_a, flat_b} !== '0) begin
      errors++; $display("FAIL async_reset: got rd=%h rv=%b err=%b flat_a=%h flat_b=%h, expected all zero", rd_a, rv_a, err_a, flat_a, flat_b);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rd_a, rv_a, err_a, rd_b, rv_b, err_b} !== '0) begin
      errors++; $display("FAIL post_reset_pulse: got rv_a=%b rd_a=%h err_a=%b rv_b=%b, expected all zero", rv_a, rd_a, err_a, rv_b);
    end
  endtask

`ifdef DEVICE_REGS_SHADOW_EN
  task automatic test_shadow();
    apply(1'b1, 1'b0, 4'd0, 8'hC3, 1'b0);
    checks++;
    if (flat_a[7:0] !== 8'h00) begin
      errors++; $display("FAIL shadow_hidden: got %h, expected 00", flat_a[7:0]);
    end
    apply(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    checks++;
    if (flat_a[7:0] !== 8'hC3) begin
      errors++; $display("FAIL shadow_commit: got %h, expected c3", flat_a[7:0]);
    end
    apply(1'b1, 1'b0, 4'd0, 8'h7E, 1'b1);
    checks++;
    if (flat_a[7:0] !== 8'hC3) begin
      errors++; $display("FAIL commit_with_write: got %h, expected c3", flat_a[7:0]);
    end
    apply(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    checks++;
    if (flat_a[7:0] !== 8'h7E) begin
      errors++; $display("FAIL second_commit: got %h, expected 7e", flat_a[7:0]);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_same_cycle_rw();
    test_protect();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
`ifdef DEVICE_REGS_SHADOW_EN
    test_shadow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
